// File: rtl/uart_block_framer_pkg.sv
// rtl/uart_block_framer_pkg.sv - shared types and constants for the UART block framer
package uart_block_framer_pkg;

    localparam int BLK_W     = 128;
    localparam int BLK_BYTES = 16;
    localparam int CNT_W     = 5;

    localparam logic [7:0] CMD_BLOCK_DEF = 8'h50;
    localparam logic [7:0] ERR_BYTE_DEF  = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_SEND,
        ST_GAP
    } state_e;

    // Upper- and lower-case forms of the command letter are both accepted.
    function automatic logic is_block_cmd(input logic [7:0] b, input logic [7:0] cmd);
        return (b == cmd) || (b == (cmd | 8'h20));
    endfunction

endpackage

// File: rtl/uart_block_framer_byte_serializer.sv
// rtl/uart_block_framer_byte_serializer.sv - shifts a loaded block out as bytes with a one-cycle gap
module uart_block_framer_byte_serializer
    import uart_block_framer_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [BLK_W-1:0] load_data_i,
    input  logic [CNT_W-1:0] load_count_i,
    input  logic             TX_IDLE,
    output logic [7:0]       TX_DATA,
    output logic             TX_ENABLE,
    output logic             done_o
);

    state_e           phase_q;
    logic [BLK_W-1:0] shift_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       tx_data_q;
    logic             tx_enable_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            phase_q     <= ST_IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
        end else begin
            tx_enable_q <= 1'b0;
            case (phase_q)
                ST_SEND: begin
                    if (TX_IDLE) begin
                        tx_data_q   <= shift_q[BLK_W-1 -: 8];
                        tx_enable_q <= 1'b1;
                        shift_q     <= shift_q << 8;
                        count_q     <= count_q - 1'b1;
                        phase_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    phase_q <= (count_q == '0) ? ST_IDLE : ST_SEND;
                end
                default: begin
                    // A load with the transmitter idle sends its first byte straight away.
                    if (load_i) begin
                        if (TX_IDLE) begin
                            tx_data_q   <= load_data_i[BLK_W-1 -: 8];
                            tx_enable_q <= 1'b1;
                            shift_q     <= load_data_i << 8;
                            count_q     <= load_count_i - 1'b1;
                            phase_q     <= ST_GAP;
                        end else begin
                            shift_q <= load_data_i;
                            count_q <= load_count_i;
                            phase_q <= ST_SEND;
                        end
                    end
                end
            endcase
        end
    end

    assign TX_DATA   = tx_data_q;
    assign TX_ENABLE = tx_enable_q;
    assign done_o    = (phase_q == ST_GAP) && (count_q == '0);

endmodule

// File: rtl/uart_block_framer.sv
// rtl/uart_block_framer.sv - frames UART bytes into 128-bit blocks and serialises results back
module uart_block_framer
    import uart_block_framer_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 12_000_000,
    parameter logic [7:0] CMD_BLOCK      = CMD_BLOCK_DEF,
    parameter logic [7:0] ERR_BYTE       = ERR_BYTE_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       RX_DATA,
    input  logic             RX_READY,
    input  logic             TX_IDLE,
    output logic [7:0]       TX_DATA,
    output logic             TX_ENABLE,
    output logic [BLK_W-1:0] BLK_DATA,
    output logic             BLK_VALID,
    input  logic             BLK_READY,
    input  logic [BLK_W-1:0] RES_DATA,
    input  logic             RES_VALID,
    output logic             BUSY
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX = 4'(BLK_BYTES - 1);

    state_e           state_q, state_d;
    logic [3:0]       byte_cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic [BLK_W-1:0] blk_data_q;
    logic             blk_valid_q;
    logic             busy_q;

    logic             ser_load;
    logic [BLK_W-1:0] ser_data;
    logic [CNT_W-1:0] ser_count;
    logic             ser_done;
    logic             rx_cmd;

    assign rx_cmd = is_block_cmd(RX_DATA, CMD_BLOCK);

    // A byte in the expiry cycle wins over the timeout.
    always_comb begin
        state_d   = state_q;
        ser_load  = 1'b0;
        ser_data  = {ERR_BYTE, {(BLK_W-8){1'b0}}};
        ser_count = CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (RX_READY) begin
                    if (rx_cmd) begin
                        state_d = ST_COLLECT;
                    end else begin
                        ser_load = 1'b1;
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_COLLECT: begin
                if (RX_READY) begin
                    if (byte_cnt_q == LAST_IDX) state_d = ST_ISSUE;
                end else if (tmo_q == TMO_LAST) begin
                    ser_load = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_ISSUE: begin
                if (BLK_READY) state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (RES_VALID) begin
                    ser_load  = 1'b1;
                    ser_data  = RES_DATA;
                    ser_count = CNT_W'(BLK_BYTES);
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            tmo_q       <= '0;
            blk_data_q  <= '0;
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != ST_IDLE);
            blk_valid_q <= (state_d == ST_ISSUE);
            case (state_q)
                ST_IDLE: begin
                    if (RX_READY && rx_cmd) begin
                        byte_cnt_q <= '0;
                        tmo_q      <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (RX_READY) begin
                        blk_data_q <= {blk_data_q[BLK_W-9:0], RX_DATA};
                        tmo_q      <= '0;
                        if (byte_cnt_q != LAST_IDX) byte_cnt_q <= byte_cnt_q + 1'b1;
                    end else if (tmo_q != TMO_LAST) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    uart_block_framer_byte_serializer u_ser (
        .CLK          (CLK),
        .RST          (RST),
        .load_i       (ser_load),
        .load_data_i  (ser_data),
        .load_count_i (ser_count),
        .TX_IDLE      (TX_IDLE),
        .TX_DATA      (TX_DATA),
        .TX_ENABLE    (TX_ENABLE),
        .done_o       (ser_done)
    );

    assign BLK_DATA  = blk_data_q;
    assign BLK_VALID = blk_valid_q;
    assign BUSY      = busy_q;

endmodule
